fft_output_buffer: RTL and testbench
====================================

# fft_output_buffer

Receives the streaming complex output of the FFT core and converts each bin to an unsigned squared magnitude. Complete frames are stored in a ping-pong pair of NSamples-deep banks. Stored frames are replayed to the spectral/display logic over a valid/ready stream. It is the read-side counterpart of fft_input_buffer: that block feeds the FFT, this one drains it.

## Interface
- W, 16: signed width of FFT real/imag outputs.
- NSamples, 32: bins per frame; power of two, ≥ 4.
- clk  in  1  system clock; all logic is single-clock.
- reset  in  1  asynchronous, active-low reset.
- fft_output_real  in  W  signed real part of current bin.
- fft_output_imag  in  W  signed imaginary part of current bin.
- fft_output_valid  in  1  bin qualifier; the FFT cannot be stalled, so there is no ready.
- fft_output_sop  in  1  first bin of a frame; only meaningful with valid.
- fft_output_eop  in  1  last bin of a frame; only meaningful with valid.
- mag_data  out  2W  unsigned re²+im².
- mag_bin  out  $clog2(NSamples)  bin index of mag_data.
- mag_valid  out  1  output qualifier.
- mag_ready  in  1  downstream accept.
- mag_last  out  1  marks bin NSamples-1.
- frame_dropped  out  1  one-cycle pulse: a frame was discarded because both banks were full.
- frame_error  out  1  one-cycle pulse: malformed frame discarded.

## Operation
- Magnitude:
  - re² and im² are computed as full-precision signed products and summed unsigned into 2W bits.
  - The sum cannot overflow: the maximum is 2·2^(2W-2) = 2^(2W-1).
  - Example: (-32768, -32768) → 0x8000_0000.
- Write FSM states:
  - W_IDLE: wait for valid&sop.
    - If the target bank is free: write bin 0, go to W_FILL.
    - If both banks are full: assert the frame_dropped pulse, go to W_SKIP.
  - W_FILL: each valid writes the next bin index.
    - valid&eop at index NSamples-1: mark the bank full after the pipeline flushes, toggle wr_bank, go to W_IDLE.
    - eop at any other index: frame_error, bank contents discarded, go to W_IDLE.
    - sop mid-frame: frame_error, restart the same bank at index 0 with this bin.
    - Index reaching NSamples-1 without eop: also frame_error.
  - W_SKIP: ignore bins until valid&eop, then go to W_IDLE.
  - valid without sop while in W_IDLE is ignored.
- Read FSM states:
  - R_IDLE: when bank rd_bank is full, go to R_FETCH.
  - R_FETCH: one-cycle memory read of bin 0, then go to R_STREAM.
  - R_STREAM:
    - mag_valid is held high; data, bin and last stay stable until mag_ready.
    - On each handshake the next bin is presented on the following cycle, with no bubble; the memory read is prefetched.
    - On the handshake with mag_last: mark the bank free, toggle rd_bank, go to R_IDLE.
- Bank flags:
  - full[1:0], set by the write side and cleared by the read side.
  - Set and clear of different banks in the same cycle are both honoured.
  - A bank being read is never written.

## Timing
- Reset values:
  - All outputs are 0: mag_valid=0, mag_last=0, mag_data=0, mag_bin=0, frame_dropped=0, frame_error=0.
  - full=2'b00, wr_bank=rd_bank=0, both FSMs in their idle state.
- Magnitude pipeline is 2 stages: product registers, then sum+write.
  - Bin k accepted at cycle t is in memory at t+2.
- Bank becomes full at cycle e+2, where e is the eop cycle.
- mag_valid first rises at e+4 when the read side is idle and mag_ready is ignored; path is R_IDLE → R_FETCH → R_STREAM.
- Throughput is one bin per cycle when mag_ready is held high. A frame drains in NSamples cycles.
- Back-to-back frames with no gap are accepted while a bank is free.
- Asserting reset mid-frame or mid-stream aborts immediately and discards both banks.
- Memory contents are not cleared by reset; the flags govern validity.

## Structure
- audio_pkg holds shared items:
  - W default constant.
  - Typedefs sample_t (signed W) and mag_t (unsigned 2W).
  - wr_state_t and rd_state_t enums.
- One sub-module: fft_mag_sq, the 2-stage squarer with a valid pipeline. It is reusable by the spectrum display path.
- Banks are inferred as a single 2·NSamples × 2W memory. The address is {bank, bin}.

## Test plan
- Single frame, re=bin, im=0, mag_ready=1 → 32 outputs with mag_data=bin², mag_bin 0..31, mag_last only at bin 31, first mag_valid at e+4.
- Extreme values (-32768, -32768) and (32767, -32768) → 0x8000_0000 and 0x7FFF_0001; no wrap.
- Three back-to-back frames with mag_ready=0 → frames 1–2 buffered; frame_dropped pulses once at frame 3's sop; after releasing ready, frames 1 then 2 are output intact.
- eop at bin 10 → one frame_error pulse, no output. The next well-formed frame is output normally.
- mag_ready toggled randomly → every bin delivered exactly once, in order, and held stable while stalled.
- reset asserted during R_STREAM at bin 5 → mag_valid=0 asynchronously. After release, no stale frame is output; the next frame starts at bin 0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared widths, sample/magnitude types and FSM encodings for the FFT
// output path.
package audio_pkg;
  localparam int W_DEFAULT = 16;

  typedef logic signed [W_DEFAULT-1:0] sample_t;
  typedef logic [2*W_DEFAULT-1:0]      mag_t;

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_SKIP}    wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rd_state_t;
endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage re^2+im^2 squarer: product registers, then a registered sum.
// An opaque tag rides alongside so callers can carry address/control bits.
module fft_mag_sq #(
  parameter int W     = 16,
  parameter int TAG_W = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  output logic [2*W-1:0]      out_mag,
  output logic [TAG_W-1:0]    out_tag
);
  localparam int STAGES = 2;

  logic [STAGES:1]       vld_pipe;
  logic signed [2*W-1:0] sq_re, sq_im;
  logic [TAG_W-1:0]      tag_q;

  always_ff @(posedge clk or negedge reset)
    if (!reset) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};

  // Each square is non-negative and at most 2^(2W-2), so the unsigned sum
  // fits in 2W bits without wrapping.
  always_ff @(posedge clk) begin
    sq_re   <= in_re * in_re;
    sq_im   <= in_im * in_im;
    tag_q   <= in_tag;
    out_mag <= $unsigned(sq_re) + $unsigned(sq_im);
    out_tag <= tag_q;
  end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: rtl/fft_output_buffer.sv
// Ping-pong frame buffer between the FFT core and spectral consumers:
// squares each bin, stores whole frames, replays them over valid/ready.
module fft_output_buffer
  import audio_pkg::*;
#(
  parameter int W        = W_DEFAULT,
  parameter int NSamples = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [W-1:0]         fft_output_real,
  input  logic signed [W-1:0]         fft_output_imag,
  input  logic                        fft_output_valid,
  input  logic                        fft_output_sop,
  input  logic                        fft_output_eop,
  output logic [2*W-1:0]              mag_data,
  output logic [$clog2(NSamples)-1:0] mag_bin,
  output logic                        mag_valid,
  input  logic                        mag_ready,
  output logic                        mag_last,
  output logic                        frame_dropped,
  output logic                        frame_error
);
  localparam int            BW    = $clog2(NSamples);
  localparam int            TAG_W = BW + 2;  // {commit, bank, bin}
  localparam logic [BW-1:0] LAST  = BW'(NSamples - 1);

  wr_state_t     wr_state, wr_next;
  logic [BW-1:0] wr_idx, wr_acc_idx;
  logic          wr_bank, wr_acc, wr_commit, wr_err, wr_drop;

  rd_state_t     rd_state, rd_next;
  logic          rd_bank, rd_done, rd_load;
  logic [BW-1:0] rd_addr_bin;

  logic [1:0]       full, set_full, clr_full;
  logic             sq_valid;
  logic [2*W-1:0]   sq_mag;
  logic [TAG_W-1:0] sq_tag;
  logic [2*W-1:0]   mem [2*NSamples];

  // ---------------- write side ----------------
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_state      <= W_IDLE;
      wr_idx        <= '0;
      wr_bank       <= 1'b0;
      frame_dropped <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      wr_state      <= wr_next;
      if (wr_acc)    wr_idx  <= wr_acc_idx + BW'(1);
      if (wr_commit) wr_bank <= ~wr_bank;
      frame_dropped <= wr_drop;
      frame_error   <= wr_err;
    end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (wr_drop) wr_next = W_SKIP;
               else if (wr_acc) wr_next = W_FILL;
      W_FILL:  if (wr_commit || (wr_err && !fft_output_sop)) wr_next = W_IDLE;
      W_SKIP:  if (fft_output_valid && fft_output_eop) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // A full target bank means both are full: banks fill and drain in the
  // same alternating order, so the target is always the older frame.
  always_comb begin
    wr_acc     = 1'b0;
    wr_acc_idx = wr_idx;
    wr_commit  = 1'b0;
    wr_err     = 1'b0;
    wr_drop    = 1'b0;
    case (wr_state)
      W_IDLE: if (fft_output_valid && fft_output_sop) begin
        if (full[wr_bank]) wr_drop = 1'b1;
        else begin
          wr_acc     = 1'b1;
          wr_acc_idx = '0;
        end
      end
      W_FILL: if (fft_output_valid) begin
        wr_acc = 1'b1;
        if (fft_output_sop) begin
          wr_err     = 1'b1;
          wr_acc_idx = '0;
        end else if (wr_idx == LAST) begin
          if (fft_output_eop) wr_commit = 1'b1;
          else                wr_err    = 1'b1;
        end else if (fft_output_eop) wr_err = 1'b1;
      end
      default: ;
    endcase
  end

  // Commit travels with the last bin so the bank turns full on the same
  // edge its final magnitude lands in memory.
  fft_mag_sq #(.W(W), .TAG_W(TAG_W)) u_mag_sq (
    .clk      (clk),
    .reset    (reset),
    .in_valid (wr_acc),
    .in_re    (fft_output_real),
    .in_im    (fft_output_imag),
    .in_tag   ({wr_commit, wr_bank, wr_acc_idx}),
    .out_valid(sq_valid),
    .out_mag  (sq_mag),
    .out_tag  (sq_tag)
  );

  always_ff @(posedge clk)
    if (sq_valid) mem[sq_tag[BW:0]] <= sq_mag;

  // ---------------- bank flags ----------------
  assign set_full = (sq_valid && sq_tag[TAG_W-1]) ? (2'b01 << sq_tag[BW]) : 2'b00;
  assign clr_full = rd_done ? (2'b01 << rd_bank) : 2'b00;

  always_ff @(posedge clk or negedge reset)
    if (!reset) full <= 2'b00;
    else        full <= (full & ~clr_full) | set_full;

  // ---------------- read side ----------------
  assign rd_done     = (rd_state == R_STREAM) && mag_ready && mag_last;
  assign rd_load     = (rd_state == R_FETCH) ||
                       ((rd_state == R_STREAM) && mag_ready && !mag_last);
  assign rd_addr_bin = (rd_state == R_FETCH) ? '0 : mag_bin + BW'(1);

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_state <= R_IDLE;
      rd_bank  <= 1'b0;
      mag_data <= '0;
      mag_bin  <= '0;
    end else begin
      rd_state <= rd_next;
      if (rd_done) rd_bank <= ~rd_bank;
      if (rd_load) begin
        mag_data <= mem[{rd_bank, rd_addr_bin}];
        mag_bin  <= rd_addr_bin;
      end
    end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:   if (full[rd_bank]) rd_next = R_FETCH;
      R_FETCH:  rd_next = R_STREAM;
      R_STREAM: if (rd_done) rd_next = R_IDLE;
      default:  rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    mag_valid = (rd_state == R_STREAM);
    mag_last  = mag_valid && (mag_bin == LAST);
  end
endmodule

// File: tb/tb_fft_output_buffer.sv
// Self-checking bench: queue scoreboard fed by a frame-level model, a
// vector table for extreme magnitudes, and directed multi-cycle corners.
module tb_fft_output_buffer;
  import audio_pkg::*;

  localparam int W = 16;
  localparam int N = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic signed [W-1:0] fft_output_real = '0, fft_output_imag = '0;
  logic              fft_output_valid = 1'b0, fft_output_sop = 1'b0, fft_output_eop = 1'b0;
  logic [2*W-1:0]    mag_data;
  logic [4:0]        mag_bin;
  logic              mag_valid, mag_last, frame_dropped, frame_error;
  logic              mag_ready = 1'b0;

  fft_output_buffer #(.W(W), .NSamples(N)) dut (
    .clk             (clk),
    .reset           (reset),
    .fft_output_real (fft_output_real),
    .fft_output_imag (fft_output_imag),
    .fft_output_valid(fft_output_valid),
    .fft_output_sop  (fft_output_sop),
    .fft_output_eop  (fft_output_eop),
    .mag_data        (mag_data),
    .mag_bin         (mag_bin),
    .mag_valid       (mag_valid),
    .mag_ready       (mag_ready),
    .mag_last        (mag_last),
    .frame_dropped   (frame_dropped),
    .frame_error     (frame_error)
  );

  always #5 clk = ~clk;

  typedef struct { mag_t mag; int bin; } exp_t;
  typedef struct { sample_t re; sample_t im; mag_t exp; } vec_t;

  int      total = 0, bad = 0;
  exp_t    exp_q[$];
  int      stored = 0, exp_drops = 0;
  int      drops_seen = 0, errs_seen = 0;
  logic    rnd_ready = 1'b0;
  sample_t fr_re[N], fr_im[N];
  mag_t    fr_ex[N];
  vec_t    vt[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic mag_t mag_of(input int re, input int im);
    longint s;
    s = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    return s[31:0];
  endfunction

  // Scoreboard / protocol monitor, sampled mid-cycle.
  logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [31:0] pd = '0;
  logic [4:0] pb = '0;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (reset) begin
      if (frame_dropped) drops_seen++;
      if (frame_error)   errs_seen++;
      if (pv && !pr) begin
        check("hold_valid", mag_valid, 1'b1);
        check("hold_data", mag_data, pd);
        check("hold_bin", mag_bin, pb);
        check("hold_last", mag_last, pl);
      end
      if (mag_valid && mag_ready) begin
        if (exp_q.size() == 0) check("spurious_out", exp_q.size(), 1);
        else begin
          mon_e = exp_q.pop_front();
          check("data", mag_data, mon_e.mag);
          check("bin", mag_bin, mon_e.bin);
          check("last", mag_last, mon_e.bin == N-1);
          if (mon_e.bin == N-1) stored--;
        end
      end
      pv = mag_valid; pr = mag_ready; pd = mag_data; pb = mag_bin; pl = mag_last;
    end else pv = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) mag_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_bin(input sample_t re, input sample_t im, input logic sop, input logic eop);
    fft_output_real = re; fft_output_imag = im;
    fft_output_valid = 1'b1; fft_output_sop = sop; fft_output_eop = eop;
    tick();
    fft_output_valid = 1'b0; fft_output_sop = 1'b0; fft_output_eop = 1'b0;
  endtask

  // Frame-level model: a frame is kept if fewer than two are held/pending.
  task automatic send_frame();
    if (stored < 2) begin
      stored++;
      for (int k = 0; k < N; k++) exp_q.push_back('{mag: fr_ex[k], bin: k});
    end else exp_drops++;
    for (int k = 0; k < N; k++) send_bin(fr_re[k], fr_im[k], k == 0, k == N-1);
  endtask

  task automatic gen_rand();
    for (int k = 0; k < N; k++) begin
      fr_re[k] = 16'($urandom);
      fr_im[k] = 16'($urandom);
      fr_ex[k] = mag_of(fr_re[k], fr_im[k]);
    end
  endtask

  task automatic gen_ramp();
    for (int k = 0; k < N; k++) begin
      fr_re[k] = 16'(k);
      fr_im[k] = '0;
      fr_ex[k] = 32'(k * k);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mag_valid) && n < budget) begin
      tick();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    check("drain_valid", mag_valid, 1'b0);
  endtask

  initial begin
    int n, d0, e0, m0;
    vt[0] = '{16'sh8000, 16'sh8000, 32'h8000_0000};
    vt[1] = '{16'sh7FFF, 16'sh8000, 32'h7FFF_0001};
    vt[2] = '{16'sh7FFF, 16'sh7FFF, 32'h7FFE_0002};
    vt[3] = '{16'sh0000, 16'sh0000, 32'h0000_0000};
    vt[4] = '{16'sh0003, 16'sh0004, 32'd25};
    vt[5] = '{16'shFFFD, 16'sh0004, 32'd25};
    vt[6] = '{16'shFFFF, 16'shFFFF, 32'd2};
    vt[7] = '{16'sh0064, 16'shFF38, 32'd50000};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", mag_valid, 0);
    check("rst_last", mag_last, 0);
    check("rst_data", mag_data, 0);
    check("rst_bin", mag_bin, 0);
    check("rst_drop", frame_dropped, 0);
    check("rst_err", frame_error, 0);
    reset = 1'b1;
    tick(); tick();

    // ramp frame, latency from eop to first valid
    mag_ready = 1'b1;
    gen_ramp();
    send_frame();
    n = 0;
    while (!mag_valid && n < 20) begin tick(); n++; end
    check("first_valid_lat", n, 4);
    wait_drain(200);

    // extreme-value vector table
    for (int k = 0; k < N; k++) begin
      fr_re[k] = vt[k % 8].re;
      fr_im[k] = vt[k % 8].im;
      fr_ex[k] = vt[k % 8].exp;
    end
    send_frame();
    wait_drain(200);

    // three back-to-back frames while stalled: third is dropped
    mag_ready = 1'b0;
    d0 = drops_seen; m0 = exp_drops;
    for (int f = 0; f < 3; f++) begin gen_rand(); send_frame(); end
    repeat (5) tick();
    check("drop_pulses", drops_seen - d0, 1);
    check("drop_model", drops_seen - d0, exp_drops - m0);
    check("stall_valid", mag_valid, 1'b1);
    check("stall_bin", mag_bin, 0);
    mag_ready = 1'b1;
    wait_drain(400);

    // early eop at bin 10, then a good frame
    e0 = errs_seen;
    for (int k = 0; k <= 10; k++) send_bin(16'($urandom), 16'($urandom), k == 0, k == 10);
    repeat (12) tick();
    check("eop_err_pulses", errs_seen - e0, 1);
    check("eop_err_no_out", mag_valid, 1'b0);
    gen_rand();
    send_frame();
    wait_drain(200);

    // sop mid-frame restarts the bank with the new frame
    e0 = errs_seen;
    for (int k = 0; k < 5; k++) send_bin(16'($urandom), 16'($urandom), k == 0, 1'b0);
    gen_rand();
    send_frame();
    wait_drain(200);
    check("sop_err_pulses", errs_seen - e0, 1);

    // random stalls and gaps
    rnd_ready = 1'b1;
    d0 = drops_seen; m0 = exp_drops;
    for (int f = 0; f < 6; f++) begin
      gen_rand();
      send_frame();
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_drain(3000);
    rnd_ready = 1'b0;
    check("rand_drops", drops_seen - d0, exp_drops - m0);

    // reset mid-stream at bin 5
    mag_ready = 1'b1;
    gen_rand();
    send_frame();
    n = 0;
    while (!(mag_valid && mag_bin == 5) && n < 100) begin tick(); n++; end
    check("reach_bin5", mag_bin, 5);
    reset = 1'b0;
    #1;
    check("arst_valid", mag_valid, 1'b0);
    check("arst_last", mag_last, 1'b0);
    check("arst_data", mag_data, 0);
    exp_q.delete();
    stored = 0;
    tick(); tick();
    reset = 1'b1;
    repeat (10) tick();
    check("no_stale_frame", mag_valid, 1'b0);
    gen_ramp();
    send_frame();
    wait_drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
